// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, FSM encoding and default sizing for the 7-segment path
package seg7_pkg;

    localparam int DEF_DIGITS = 8;

    // Active-low patterns with dp off (bit7 = 1), index = hex nibble
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: inverse glyph lookup, segment pattern to hex nibble
//   pat   : active-low segments g..a (dp excluded)
//   nib   : decoded hex nibble (0 when not legal)
//   legal : pattern matches one of the 16 hex glyphs
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       legal
);

    always_comb begin
        nib   = '0;
        legal = 1'b0;
        for (int k = 0; k < 16; k++)
            if ({1'b1, pat} == GLYPH[k]) begin
                nib   = 4'(k);
                legal = 1'b1;
            end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment scan and rebuilds the displayed word
//   clk, rst   : clock, asynchronous active-high reset
//   an         : active-low digit enables, one low per lit digit
//   seg        : active-low segments, bit7 = dp, bits6..0 = g..a
//   value      : last complete frame, digit i at bits 4i+3..4i
//   frame_done : one-cycle pulse aligned with a new value
//   digit_seen : digits captured so far in the current frame
//   err        : one-cycle pulse on a stable non-hex pattern
//   err_digit  : digit index of the last err
//   dp         : captured decimal points, only with SEG7_DP_CAPTURE_EN defined
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = DEF_DIGITS,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS-1:0]         an,
    input  logic [7:0]                    seg,
    output logic [4*NUM_DIGITS-1:0]       value,
    output logic                          frame_done,
    output logic [NUM_DIGITS-1:0]         digit_seen,
    output logic                          err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]         dp
`endif
);

    localparam int IW = $clog2(NUM_DIGITS);
`ifdef SEG7_DP_CAPTURE_EN
    localparam int SEGW = 8;
`else
    localparam int SEGW = 7;
`endif
    localparam int SW = NUM_DIGITS + SEGW;
    localparam logic [7:0] STB = 8'(STABLE_CYCLES);

    logic [SW-1:0] raw, s, p;

`ifdef SEG7_DP_CAPTURE_EN
    assign raw = {an, seg};
`else
    logic unused_dp;
    assign unused_dp = seg[7];
    assign raw = {an, seg[6:0]};
`endif

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = raw;
        end else begin : g_sync
            logic [SW-1:0] chain [SYNC_STAGES];
            // Chain idles at all-ones so reset looks like a blank display
            always_ff @(posedge clk or posedge rst)
                if (rst)
                    for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '1;
                else begin
                    chain[0] <= raw;
                    for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
                end
            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    wire [NUM_DIGITS-1:0] s_an = s[SW-1 -: NUM_DIGITS];
    wire [NUM_DIGITS-1:0] p_an = p[SW-1 -: NUM_DIGITS];
    wire valid   = $onehot(~s_an);
    wire changed = s != p;

    state_t state, state_n;
    logic [7:0] cnt, cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!valid) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE || changed) begin
            state_n = TRACK;
            cnt_n   = 8'd1;
        end else if (state == TRACK) begin
            state_n = cnt == STB ? HOLD : TRACK;
            cnt_n   = cnt == STB ? cnt : cnt + 8'd1;
        end
    end

    // cnt counts how many consecutive samples p has held, so p is what gets captured
    wire capture = state == TRACK && cnt == STB;

    logic [IW-1:0] idx;
    logic [3:0] nib;
    logic legal;
    logic [NUM_DIGITS-1:0][3:0] shadow, shadow_n;
    logic [NUM_DIGITS-1:0] seen_n;

    seg7_glyph_decode u_dec (.pat(p[6:0]), .nib(nib), .legal(legal));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!p_an[i]) idx = IW'(i);
        shadow_n = shadow;
        shadow_n[idx] = nib;
        seen_n = digit_seen | (NUM_DIGITS'(1) << idx);
    end

`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_shadow, dp_n;
    always_comb begin
        dp_n = dp_shadow;
        dp_n[idx] = ~p[7];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dp_shadow <= '0;
            dp        <= '0;
        end else if (capture && legal) begin
            dp_shadow <= dp_n;
            if (&seen_n) dp <= dp_n;
        end
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            p          <= '1;
            shadow     <= '0;
            value      <= '0;
            frame_done <= 1'b0;
            digit_seen <= '0;
            err        <= 1'b0;
            err_digit  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            p          <= s;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (capture && legal) begin
                shadow     <= shadow_n;
                digit_seen <= &seen_n ? '0 : seen_n;
                if (&seen_n) begin
                    value      <= shadow_n;
                    frame_done <= 1'b1;
                end
            end else if (capture) begin
                err       <= 1'b1;
                err_digit <= idx;
            end
        end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench for the 7-segment scan decoder
module tb_seg7_scan_decoder;

    logic        clk, rst;
    logic [7:0]  an, seg;
    logic [31:0] value;
    logic        frame_done, err;
    logic [7:0]  digit_seen;
    logic [2:0]  err_digit;
`ifdef SEG7_DP_CAPTURE_EN
    logic [7:0]  dp;
`endif

    seg7_scan_decoder dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .value(value),
        .frame_done(frame_done), .digit_seen(digit_seen), .err(err), .err_digit(err_digit)
`ifdef SEG7_DP_CAPTURE_EN
        , .dp(dp)
`endif
    );

    typedef struct {
        logic [31:0] v;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_q [$];
    int   err_q [$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic show(input int d, input logic [7:0] g, input int n);
        an  = ~(8'(1) << d);
        seg = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] w, input logic [7:0] dpm,
                        input int from, input int to, input bit ghost);
        logic [7:0] g;
        for (int d = from; d <= to; d++) begin
            g = glyph[w[4*d +: 4]];
            g[7] = ~dpm[d];
            if (ghost) show(d, seg, 1);
            show(d, g, 10);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ed;
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected value=%h", value);
            end else begin
                e = exp_q.pop_front();
                chk("frame_value", value, e.v);
`ifdef SEG7_DP_CAPTURE_EN
                chk("frame_dp", {24'b0, dp}, {24'b0, e.d});
`endif
            end
        end
        if (err) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL err_unexpected err_digit=%0d", err_digit);
            end else begin
                ed = err_q.pop_front();
                chk("err_digit", {29'b0, err_digit}, ed);
            end
        end
    end

    initial begin
        rst = 1'b1;
        an  = 8'hFF;
        seg = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_value", value, 0);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("rst_digit_seen", {24'b0, digit_seen}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_err_digit", {29'b0, err_digit}, 0);
        rst = 1'b0;
        idle(3);

        exp_q.push_back('{32'h1234ABCD, 8'h00});
        scan(32'h1234ABCD, 8'h00, 0, 7, 1'b0);
        idle(5);

        exp_q.push_back('{32'h1234ABCD, 8'h00});
        scan(32'h1234ABCD, 8'h00, 0, 7, 1'b1);
        idle(5);

        scan(32'h89ABCDEF, 8'h00, 0, 4, 1'b0);
        err_q.push_back(5);
        show(5, 8'hFF, 10);
        chk("illegal_seen", {24'b0, digit_seen}, 32'h1F);
        scan(32'h89ABCDEF, 8'h00, 6, 7, 1'b0);
        chk("withheld_seen", {24'b0, digit_seen}, 32'hDF);
        exp_q.push_back('{32'h89ABCDEF, 8'h00});
        scan(32'h89ABCDEF, 8'h00, 5, 5, 1'b0);
        idle(5);

        scan(32'hDEADBEEF, 8'h00, 0, 0, 1'b0);
        an  = 8'hFF;
        seg = 8'hC0;
        repeat (20) @(negedge clk);
        an  = 8'b1111_0011;
        repeat (20) @(negedge clk);
        chk("invalid_an_seen", {24'b0, digit_seen}, 32'h01);

        scan(32'hDEADBEEF, 8'h00, 1, 4, 1'b0);
        chk("midframe_seen", {24'b0, digit_seen}, 32'h1F);
        #2 rst = 1'b1;
        #1;
        chk("async_value", value, 0);
        chk("async_digit_seen", {24'b0, digit_seen}, 0);
        chk("async_err_digit", {29'b0, err_digit}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{32'hDEADBEEF, 8'h00});
        scan(32'hDEADBEEF, 8'h00, 0, 7, 1'b0);
        idle(5);

        exp_q.push_back('{32'h1234ABCD, 8'h81});
        scan(32'h1234ABCD, 8'h81, 0, 7, 1'b0);
        idle(10);

        chk("frames_pending", exp_q.size(), 0);
        chk("errs_pending", err_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
